// File: rtl/datapath_regs.sv
// Register file, shared bus mux and ALU for the processor datapath under the control FSM.
// Latency: bus/ALU/dmem strobes are combinational; register loads and increments land 1 cycle after the strobe.
// Backpressure: none; strobes are honoured every cycle and memory data is taken as valid when selected.
module datapath_regs #(
  parameter int DATA_W  = 16,
  parameter int IADDR_W = 8,
  parameter int DADDR_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         read_en,
  input  logic [15:0]        write_en,
  input  logic [15:0]        inc_en,
  input  logic [2:0]         alu_op,
  input  logic [DATA_W-1:0]  imem_data,
  input  logic [DATA_W-1:0]  dmem_rdata,
  output logic [DATA_W-1:0]  instruction,
  output logic [DATA_W-1:0]  z,
  output logic [IADDR_W-1:0] imem_addr,
  output logic [DADDR_W-1:0] dmem_addr,
  output logic               dmem_we,
  output logic [DATA_W-1:0]  dmem_wdata,
  output logic [DATA_W-1:0]  bus
);

  localparam logic [DATA_W-1:0] ONE = {{(DATA_W-1){1'b0}}, 1'b1};

  logic [DATA_W-1:0] pc, dar, ir, ac, r;
  logic [DATA_W-1:0] r1, r2, r3, r4, r5;
  logic              z_flag;
  logic [DATA_W-1:0] bus_val;
  logic [DATA_W-1:0] alu_result;

  // Strobe bits with no target and address bits above the memory widths are dropped on purpose.
  logic unused_bits;
  assign unused_bits = ^{write_en[0], write_en[3], write_en[13], inc_en[0], inc_en[15:7],
                         pc[DATA_W-1:IADDR_W], dar[DATA_W-1:DADDR_W]};

  // Shared bus: one source per read_en code, unlisted codes read as zero.
  always_comb begin
    bus_val = '0;
    case (read_en)
      4'd2:    bus_val = dar;
      4'd5:    bus_val = ac;
      4'd6:    bus_val = r;
      4'd7:    bus_val = r1;
      4'd8:    bus_val = r2;
      4'd9:    bus_val = r3;
      4'd10:   bus_val = r4;
      4'd11:   bus_val = r5;
      4'd12:   bus_val = dmem_rdata;
      4'd13:   bus_val = imem_data;
      default: bus_val = '0;
    endcase
  end

  // ALU on the current AC and R; carries and shifted-out bits are discarded.
  always_comb begin
    alu_result = ac;
    case (alu_op)
      3'd1:    alu_result = ac + r;
      3'd2:    alu_result = ac - r;
      3'd3:    alu_result = {ac[DATA_W-2:0], 1'b0};
      3'd4:    alu_result = {1'b0, ac[DATA_W-1:1]};
      default: alu_result = ac;
    endcase
  end

  // Control-path registers: a load beats an increment of the same register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc  <= '0;
      dar <= '0;
      ir  <= '0;
    end else begin
      if (write_en[1])     pc <= bus_val;
      else if (inc_en[1])  pc <= pc + ONE;
      if (write_en[2])     dar <= bus_val;
      else if (inc_en[3])  dar <= dar + ONE;
      if (write_en[4])     ir <= bus_val;
    end
  end

  // Accumulator, ALU operand and zero flag: ALU write-back beats a bus load, which beats increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ac     <= '0;
      r      <= '0;
      z_flag <= 1'b0;
    end else begin
      if (write_en[14])     ac <= alu_result;
      else if (write_en[5]) ac <= bus_val;
      else if (inc_en[2])   ac <= ac + ONE;
      if (write_en[6])      r <= bus_val;
      if (write_en[15])     z_flag <= (alu_result == '0);
    end
  end

  // General-purpose registers; R1-R3 also have increment strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1 <= '0;
      r2 <= '0;
      r3 <= '0;
      r4 <= '0;
      r5 <= '0;
    end else begin
      if (write_en[7])      r1 <= bus_val;
      else if (inc_en[4])   r1 <= r1 + ONE;
      if (write_en[8])      r2 <= bus_val;
      else if (inc_en[5])   r2 <= r2 + ONE;
      if (write_en[9])      r3 <= bus_val;
      else if (inc_en[6])   r3 <= r3 + ONE;
      if (write_en[10])     r4 <= bus_val;
      if (write_en[11])     r5 <= bus_val;
    end
  end

  assign bus         = bus_val;
  assign dmem_wdata  = bus_val;
  assign dmem_we     = write_en[12];
  assign instruction = ir;
  assign z           = {{(DATA_W-1){1'b0}}, z_flag};
  assign imem_addr   = pc[IADDR_W-1:0];
  assign dmem_addr   = dar[DADDR_W-1:0];

endmodule

// File: tb/tb_datapath_regs.sv
// Testbench for datapath_regs: directed scenarios plus randomized strobes against a reference model.
// Inputs change on the falling edge; outputs are compared 1 time unit after settling or after the rising edge.
// The model keeps registers in an array indexed by their write_en bit number.
`timescale 1ns/100ps
module tb_datapath_regs;

  logic        clk;
  logic        rst_n;
  logic [3:0]  read_en;
  logic [15:0] write_en, inc_en;
  logic [2:0]  alu_op;
  logic [15:0] imem_data, dmem_rdata;
  logic [15:0] instruction, z, dmem_wdata, bus;
  logic [7:0]  imem_addr, dmem_addr;
  logic        dmem_we;

  int errors = 0;
  int checks = 0;

  // Reference state: m_reg[b] is the register loaded by write_en[b] (1=PC,2=DAR,4=IR,5=AC,6=R,7..11=R1..R5).
  logic [15:0] m_reg [16];
  logic        m_z;
  int          inc_tgt [7] = '{0, 1, 5, 2, 7, 8, 9};

  datapath_regs dut (
    .clk(clk), .rst_n(rst_n), .read_en(read_en), .write_en(write_en), .inc_en(inc_en),
    .alu_op(alu_op), .imem_data(imem_data), .dmem_rdata(dmem_rdata),
    .instruction(instruction), .z(z), .imem_addr(imem_addr), .dmem_addr(dmem_addr),
    .dmem_we(dmem_we), .dmem_wdata(dmem_wdata), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void m_reset();
    for (int i = 0; i < 16; i++) m_reg[i] = 16'h0000;
    m_z = 1'b0;
  endfunction

  function automatic logic [15:0] m_bus(input logic [3:0] re, input logic [15:0] id, input logic [15:0] dd);
    if (re == 4'd2 || (re >= 4'd5 && re <= 4'd11)) return m_reg[re];
    if (re == 4'd12) return dd;
    if (re == 4'd13) return id;
    return 16'h0000;
  endfunction

  function automatic logic [15:0] m_alu(input logic [2:0] op);
    logic [15:0] a, b;
    a = m_reg[5];
    b = m_reg[6];
    case (op)
      3'd1:    return a + b;
      3'd2:    return a - b;
      3'd3:    return a * 16'd2;
      3'd4:    return a / 16'd2;
      default: return a;
    endcase
  endfunction

  // Apply one clock of strobes to the model: increments first, then loads overwrite, then ALU write-back.
  function automatic void m_step(input logic [3:0] re, input logic [15:0] we, input logic [15:0] ie,
                                 input logic [2:0] op, input logic [15:0] id, input logic [15:0] dd);
    logic [15:0] nxt [16];
    logic [15:0] b, alu;
    b   = m_bus(re, id, dd);
    alu = m_alu(op);
    nxt = m_reg;
    for (int i = 1; i <= 6; i++)
      if (ie[i]) nxt[inc_tgt[i]] = m_reg[inc_tgt[i]] + 16'd1;
    for (int k = 1; k <= 11; k++)
      if (k != 3 && we[k]) nxt[k] = b;
    if (we[14]) nxt[5] = alu;
    if (we[15]) m_z = (alu == 16'h0000);
    m_reg = nxt;
  endfunction

  task automatic idle();
    read_en = 4'd0; write_en = 16'h0; inc_en = 16'h0; alu_op = 3'd0;
    imem_data = 16'h0; dmem_rdata = 16'h0;
  endtask

  task automatic peek(input logic [3:0] code);
    write_en = 16'h0;
    inc_en   = 16'h0;
    read_en  = code;
    #1;
  endtask

  // One strobed cycle, compared against the model before and after the edge.
  task automatic drive(input logic [3:0] re, input logic [15:0] we, input logic [15:0] ie,
                       input logic [2:0] op, input logic [15:0] id, input logic [15:0] dd);
    logic [15:0] eb;
    @(negedge clk);
    read_en = re; write_en = we; inc_en = ie; alu_op = op; imem_data = id; dmem_rdata = dd;
    #1;
    eb = m_bus(re, id, dd);
    checks++;
    if (bus !== eb || dmem_wdata !== eb || dmem_we !== we[12]) begin
      errors++;
      $display("FAIL comb re=%0d: bus=%h wdata=%h we=%b expected bus=%h we=%b", re, bus, dmem_wdata, dmem_we, eb, we[12]);
    end
    @(posedge clk);
    m_step(re, we, ie, op, id, dd);
    #1;
    checks++;
    if (instruction !== m_reg[4] || z !== {15'h0, m_z} || imem_addr !== m_reg[1][7:0] || dmem_addr !== m_reg[2][7:0]) begin
      errors++;
      $display("FAIL state: ir=%h z=%h ia=%h da=%h expected ir=%h z=%h ia=%h da=%h",
               instruction, z, imem_addr, dmem_addr, m_reg[4], {15'h0, m_z}, m_reg[1][7:0], m_reg[2][7:0]);
    end
    write_en = 16'h0;
    inc_en   = 16'h0;
  endtask

  task automatic load(input int b, input logic [15:0] v);
    drive(4'd13, 16'd1 << b, 16'h0, 3'd0, v, 16'h0);
  endtask

  task automatic test_reset();
    logic [3:0] codes [8] = '{4'd2, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11};
    rst_n = 1'b0;
    idle();
    m_reset();
    #2;
    checks++;
    if (instruction !== 16'h0 || z !== 16'h0 || imem_addr !== 8'h0 || dmem_addr !== 8'h0) begin
      errors++;
      $display("FAIL reset_out: ir=%h z=%h ia=%h da=%h expected all 0", instruction, z, imem_addr, dmem_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    load(5, 16'h1234);
    load(1, 16'h0005);
    peek(4'd5);
    checks++;
    if (bus !== 16'h1234 || imem_addr !== 8'h05) begin
      errors++;
      $display("FAIL preload: ac=%h pc=%h expected 1234 05", bus, imem_addr);
    end
    // Reset between edges: outputs must clear before the next rising edge.
    @(negedge clk);
    read_en = 4'd5;
    rst_n = 1'b0;
    m_reset();
    #1;
    checks++;
    if (bus !== 16'h0 || imem_addr !== 8'h0 || instruction !== 16'h0 || z !== 16'h0 || dmem_addr !== 8'h0) begin
      errors++;
      $display("FAIL async_reset: ac=%h pc=%h ir=%h z=%h da=%h expected all 0", bus, imem_addr, instruction, z, dmem_addr);
    end
    // Strobes presented across an edge while in reset must be ignored.
    read_en = 4'd13; imem_data = 16'hFFFF; write_en = 16'hCFF6; inc_en = 16'h007E; alu_op = 3'd2;
    @(posedge clk);
    #1;
    write_en = 16'h0; inc_en = 16'h0;
    for (int i = 0; i < 8; i++) begin
      peek(codes[i]);
      checks++;
      if (bus !== 16'h0) begin
        errors++;
        $display("FAIL reset_hold code=%0d: got %h expected 0000", codes[i], bus);
      end
    end
    checks++;
    if (imem_addr !== 8'h0 || z !== 16'h0 || instruction !== 16'h0) begin
      errors++;
      $display("FAIL reset_hold_out: pc=%h z=%h ir=%h expected 0", imem_addr, z, instruction);
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle();
  endtask

  task automatic test_fetch();
    load(1, 16'h0007);
    drive(4'd13, 16'h0010, 16'h0, 3'd0, 16'h0003, 16'h0);
    checks++;
    if (instruction !== 16'h0003 || imem_addr !== 8'h07) begin
      errors++;
      $display("FAIL fetch: ir=%h pc=%h expected 0003 07", instruction, imem_addr);
    end
  endtask

  task automatic test_alu();
    load(5, 16'h0005);
    load(6, 16'h0005);
    drive(4'd0, 16'hC000, 16'h0, 3'd2, 16'h0, 16'h0);
    peek(4'd5);
    checks++;
    if (bus !== 16'h0000 || z !== 16'h0001) begin
      errors++;
      $display("FAIL sub_zero: ac=%h z=%h expected 0000 0001", bus, z);
    end
    load(6, 16'h0001);
    drive(4'd0, 16'hC000, 16'h0, 3'd2, 16'h0, 16'h0);
    peek(4'd5);
    checks++;
    if (bus !== 16'hFFFF || z !== 16'h0000) begin
      errors++;
      $display("FAIL sub_wrap: ac=%h z=%h expected ffff 0000", bus, z);
    end
  endtask

  task automatic test_shift_add();
    load(5, 16'h8001);
    drive(4'd0, 16'h4000, 16'h0, 3'd3, 16'h0, 16'h0);
    peek(4'd5);
    checks++;
    if (bus !== 16'h0002) begin
      errors++;
      $display("FAIL lshift: got %h expected 0002", bus);
    end
    load(5, 16'h8001);
    drive(4'd0, 16'h4000, 16'h0, 3'd4, 16'h0, 16'h0);
    peek(4'd5);
    checks++;
    if (bus !== 16'h4000) begin
      errors++;
      $display("FAIL rshift: got %h expected 4000", bus);
    end
    load(5, 16'hFFFF);
    load(6, 16'h0001);
    drive(4'd0, 16'hC000, 16'h0, 3'd1, 16'h0, 16'h0);
    peek(4'd5);
    checks++;
    if (bus !== 16'h0000 || z !== 16'h0001) begin
      errors++;
      $display("FAIL add_carry: ac=%h z=%h expected 0000 0001", bus, z);
    end
    // ALU write-back and bus load of AC together: ALU result wins.
    load(5, 16'h0003);
    load(6, 16'h0004);
    drive(4'd13, 16'h4020, 16'h0004, 3'd1, 16'h9999, 16'h0);
    peek(4'd5);
    checks++;
    if (bus !== 16'h0007) begin
      errors++;
      $display("FAIL alu_priority: got %h expected 0007", bus);
    end
  endtask

  task automatic test_inc();
    load(1, 16'hFFFF);
    drive(4'd0, 16'h0, 16'h0002, 3'd0, 16'h0, 16'h0);
    checks++;
    if (imem_addr !== 8'h00) begin
      errors++;
      $display("FAIL pc_wrap: got %h expected 00", imem_addr);
    end
    load(7, 16'hFFFF);
    drive(4'd0, 16'h0, 16'h0010, 3'd0, 16'h0, 16'h0);
    peek(4'd7);
    checks++;
    if (bus !== 16'h0000) begin
      errors++;
      $display("FAIL r1_wrap: got %h expected 0000", bus);
    end
    load(2, 16'h0010);
    drive(4'd13, 16'h0004, 16'h0008, 3'd0, 16'h0042, 16'h0);
    peek(4'd2);
    checks++;
    if (bus !== 16'h0042 || dmem_addr !== 8'h42) begin
      errors++;
      $display("FAIL load_over_inc: dar=%h da=%h expected 0042 42", bus, dmem_addr);
    end
  endtask

  task automatic test_store_load();
    load(5, 16'h00AB);
    @(negedge clk);
    read_en = 4'd5; write_en = 16'h1000;
    #1;
    checks++;
    if (dmem_we !== 1'b1 || dmem_wdata !== 16'h00AB) begin
      errors++;
      $display("FAIL store: we=%b wdata=%h expected 1 00ab", dmem_we, dmem_wdata);
    end
    write_en = 16'h0;
    #1;
    checks++;
    if (dmem_we !== 1'b0) begin
      errors++;
      $display("FAIL store_off: we=%b expected 0", dmem_we);
    end
    drive(4'd12, 16'h0020, 16'h0, 3'd0, 16'h0, 16'h7777);
    peek(4'd5);
    checks++;
    if (bus !== 16'h7777) begin
      errors++;
      $display("FAIL dmem_load: got %h expected 7777", bus);
    end
    peek(4'd3);
    checks++;
    if (bus !== 16'h0000) begin
      errors++;
      $display("FAIL unused_code: got %h expected 0000", bus);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      drive(4'($urandom_range(15, 0)), 16'($urandom), 16'($urandom), 3'($urandom_range(7, 0)),
            16'($urandom), 16'($urandom));
    end
    // Read every register back through the bus.
    for (int c = 2; c <= 11; c++) begin
      if (c == 3 || c == 4) continue;
      peek(4'(c));
      checks++;
      if (bus !== m_reg[c]) begin
        errors++;
        $display("FAIL rand_readback code=%0d: got %h expected %h", c, bus, m_reg[c]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_alu();
    test_shift_add();
    test_inc();
    test_store_load();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
